lvds_tx_framer: RTL and testbench

//  Transmit-side framer for the A1100 LVDS link. It generates the word stream

---
 rtl/lvds_tx_framer_if.sv | 31 +++
 rtl/lvds_tx_framer.sv | 162 ++++++++++++++++
 tb/tb_lvds_tx_framer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lvds_tx_framer_if.sv
// Framer signal bundle: upstream pixel stream plus the single-ended LVDS word lane.
// master = framer side (consumes the pixel stream, drives the lane),
// slave  = environment side (pixel source and OBUFDS wrapper / receiver).
interface lvds_tx_framer_if #(
  parameter int DW = 15
);
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] tx_data;
  logic          tx_group;
  logic          tx_sync;

  modport master (
    input  s_data,
    input  s_valid,
    output s_ready,
    output tx_data,
    output tx_group,
    output tx_sync
  );

  modport slave (
    output s_data,
    output s_valid,
    input  s_ready,
    input  tx_data,
    input  tx_group,
    input  tx_sync
  );
endinterface

// File: rtl/lvds_tx_framer.sv
// Transmit framer: emits SYNC / header / fixed-length payload / blanking words per line.
// Latency: a payload word accepted in cycle n is on tx_data in cycle n+1; all tx_* registered.
// Backpressure: none toward the link; s_ready is high for the whole payload window and
// missing words are padded with IDLE so every line keeps its fixed length.
module lvds_tx_framer #(
  parameter int DW         = 15,
  parameter int LINE_WORDS = 64,
  parameter int LINES      = 16,
  parameter int BLANK_CYC  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  lvds_tx_framer_if.master    bus,
  output logic                busy,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         underrun
);

  // Line index fits the header's index field; one counter serves payload and blanking.
  localparam int LW   = DW - 1;
  localparam int CMAX = (LINE_WORDS > BLANK_CYC) ? LINE_WORDS : BLANK_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [DW-1:0] SYNC_W    = {DW{1'b1}};
  localparam logic [DW-1:0] SYNC_M1   = {{(DW-1){1'b1}}, 1'b0};
  localparam logic [DW-1:0] IDLE_W    = '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] PAY_LAST  = CW'(LINE_WORDS - 1);
  localparam logic [CW-1:0] BLK_LAST  = CW'(BLANK_CYC - 1);
  localparam logic [LW-1:0] LINE_ONE  = LW'(1);
  localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HDR,
    ST_PAY,
    ST_BLANK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] line_q, line_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]   underrun_q, underrun_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic          tx_group_q, tx_group_d;
  logic          tx_sync_q, tx_sync_d;
  logic          s_ready_c;

  // State register; reset abandons any partial line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus line/word sequencing; frames always run to their last line.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SYNC;
          line_d  = '0;
        end
      end
      ST_SYNC: state_d = ST_HDR;
      ST_HDR: begin
        state_d = ST_PAY;
        cnt_d   = '0;
      end
      ST_PAY: begin
        if (cnt_q == PAY_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_BLANK: begin
        if (cnt_q == BLK_LAST) begin
          cnt_d = '0;
          if (line_q == LINE_LAST) begin
            // Frame done: enable decides between back-to-back SYNC and IDLE.
            frame_cnt_d = frame_cnt_q + 16'd1;
            line_d      = '0;
            state_d     = enable ? ST_SYNC : ST_IDLE;
          end else begin
            line_d  = line_q + LINE_ONE;
            state_d = ST_SYNC;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Word selection for the next tx cycle, payload acceptance and pad accounting.
  always_comb begin
    tx_data_d  = IDLE_W;
    tx_sync_d  = 1'b0;
    tx_group_d = line_q[0];
    underrun_d = underrun_q;
    s_ready_c  = 1'b0;
    unique case (state_q)
      ST_SYNC: begin
        tx_data_d = SYNC_W;
        tx_sync_d = 1'b1;
      end
      ST_HDR: tx_data_d = {(line_q == '0), line_q};
      ST_PAY: begin
        s_ready_c = 1'b1;
        if (bus.s_valid) begin
          // A payload word equal to SYNC would alias the line marker.
          tx_data_d = (bus.s_data == SYNC_W) ? SYNC_M1 : bus.s_data;
        end else if (underrun_q != 16'hFFFF) begin
          underrun_d = underrun_q + 16'd1;
        end
      end
      default: tx_data_d = IDLE_W;
    endcase
  end

  // Datapath registers: counters and the registered tx lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      line_q      <= '0;
      frame_cnt_q <= '0;
      underrun_q  <= '0;
      tx_data_q   <= '0;
      tx_group_q  <= 1'b0;
      tx_sync_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      frame_cnt_q <= frame_cnt_d;
      underrun_q  <= underrun_d;
      tx_data_q   <= tx_data_d;
      tx_group_q  <= tx_group_d;
      tx_sync_q   <= tx_sync_d;
    end
  end

  assign bus.s_ready  = s_ready_c;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_group = tx_group_q;
  assign bus.tx_sync  = tx_sync_q;
  assign busy         = (state_q != ST_IDLE);
  assign frame_cnt    = frame_cnt_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Bench for lvds_tx_framer: table-driven cycle vectors on a default-size instance,
// plus hand sequences for async reset mid-line and a small-frame loopback capture.
`timescale 1ns/1ps
module tb_lvds_tx_framer;
  localparam int DW = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        enable2 = 1'b0;
  logic        busy, busy2;
  logic [15:0] frame_cnt, underrun, frame_cnt2, underrun2;

  always #5 clk = ~clk;

  lvds_tx_framer_if #(.DW(DW)) bus ();
  lvds_tx_framer_if #(.DW(DW)) bus2 ();

  lvds_tx_framer #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
    .busy(busy), .frame_cnt(frame_cnt), .underrun(underrun)
  );

  lvds_tx_framer #(.DW(DW), .LINE_WORDS(4), .LINES(2), .BLANK_CYC(8)) dut_small (
    .clk(clk), .rst_n(rst_n), .enable(enable2), .bus(bus2),
    .busy(busy2), .frame_cnt(frame_cnt2), .underrun(underrun2)
  );

  typedef struct {
    int            tid;
    int            cyc;
    logic [DW-1:0] data;
    logic          grp;
    logic          sync;
    logic          rdy;
    logic          bsy;
    int            fc;   // -1: not compared
    int            ur;   // -1: not compared
  } vec_t;

  typedef struct {
    int tid;
    int n;
    int en_until;
    int gap_lo;
    int gap_hi;
    int sync_cyc;
  } cfg_t;

  vec_t vecs[$];
  cfg_t cfgs[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h want=%0h", nm, t, act, exp);
    end
  endtask

  task automatic add(input int tid, input int cyc, input int data, input int grp, input int sync,
                     input int rdy, input int bsy, input int fc, input int ur);
    vec_t v;
    v.tid = tid; v.cyc = cyc; v.data = DW'(data);
    v.grp = grp[0]; v.sync = sync[0]; v.rdy = rdy[0]; v.bsy = bsy[0];
    v.fc = fc; v.ur = ur;
    vecs.push_back(v);
  endtask

  task automatic check_vec(input vec_t v);
    string p;
    p = $sformatf("T%0d", v.tid);
    chk({p, " tx_data"}, v.cyc, 32'(bus.tx_data), 32'(v.data));
    chk({p, " tx_group"}, v.cyc, 32'(bus.tx_group), 32'(v.grp));
    chk({p, " tx_sync"}, v.cyc, 32'(bus.tx_sync), 32'(v.sync));
    chk({p, " s_ready"}, v.cyc, 32'(bus.s_ready), 32'(v.rdy));
    chk({p, " busy"}, v.cyc, 32'(busy), 32'(v.bsy));
    if (v.fc >= 0) chk({p, " frame_cnt"}, v.cyc, 32'(frame_cnt), v.fc);
    if (v.ur >= 0) chk({p, " underrun"}, v.cyc, 32'(underrun), v.ur);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // t counts negedges; inputs set at negedge t are seen by the following posedge.
  task automatic run(input cfg_t c);
    int word;
    word = 1;
    for (int t = 0; t <= c.n; t++) begin
      @(negedge clk);
      foreach (vecs[i]) if (vecs[i].tid == c.tid && vecs[i].cyc == t) check_vec(vecs[i]);
      enable = (t < c.en_until);
      bus.s_valid = !(t >= c.gap_lo && t <= c.gap_hi);
      bus.s_data = (t == c.sync_cyc) ? {DW{1'b1}} : word[DW-1:0];
      if (bus.s_ready && bus.s_valid) word++;
    end
    enable = 1'b0;
  endtask

  initial begin
    cfg_t c;
    int st, k, nl;
    int src;
    logic [DW-1:0] cap[8];
    int hdr[2];
    int grp[2];
    int srcq[$];

    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus2.s_valid = 1'b0;
    bus2.s_data = '0;

    // T1: one frame, every payload word valid, data 1,2,3...
    add(1,    0, 'h0000, 0, 0, 0, 0, 0, 0);
    add(1,    1, 'h0000, 0, 0, 0, 1, -1, -1);
    add(1,    2, 'h7FFF, 0, 1, 0, 1, -1, -1);
    add(1,    3, 'h4000, 0, 0, 1, 1, -1, -1);
    add(1,    4, 'h0001, 0, 0, 1, 1, -1, -1);
    add(1,    5, 'h0002, 0, 0, 1, 1, -1, -1);
    add(1,   67, 'h0040, 0, 0, 0, 1, -1, -1);
    add(1,   68, 'h0000, 0, 0, 0, 1, -1, -1);
    add(1,   75, 'h0000, 0, 0, 0, 1, -1, -1);
    add(1,   76, 'h7FFF, 1, 1, 0, 1, -1, -1);
    add(1,   77, 'h0001, 1, 0, 1, 1, -1, -1);
    add(1,   78, 'h0041, 1, 0, 1, 1, -1, -1);
    add(1,  141, 'h0080, 1, 0, 0, 1, -1, -1);
    add(1,  151, 'h0002, 0, 0, 1, 1, -1, -1);
    add(1, 1113, 'h000F, 1, 0, 1, 1, -1, -1);
    add(1, 1114, 'h03C1, 1, 0, 1, 1, -1, -1);
    add(1, 1177, 'h0400, 1, 0, 0, 1, 0, 0);
    add(1, 1184, 'h0000, 1, 0, 0, 1, 0, -1);
    add(1, 1185, 'h0000, 1, 0, 0, 0, 1, 0);
    add(1, 1186, 'h0000, 0, 0, 0, 0, 1, 0);
    add(1, 1190, 'h0000, 0, 0, 0, 0, 1, 0);
    // T2: pads on line 3 words 10..12, SYNC-valued input on line 4 word 5
    add(2,  234, 'h00C9, 1, 0, 1, 1, -1, 0);
    add(2,  235, 'h0000, 1, 0, 1, 1, -1, 1);
    add(2,  236, 'h0000, 1, 0, 1, 1, -1, 2);
    add(2,  237, 'h0000, 1, 0, 1, 1, -1, 3);
    add(2,  238, 'h00CA, 1, 0, 1, 1, -1, 3);
    add(2,  289, 'h00FD, 1, 0, 0, 1, -1, 3);
    add(2,  297, 'h0000, 1, 0, 0, 1, -1, -1);
    add(2,  298, 'h7FFF, 0, 1, 0, 1, -1, -1);
    add(2,  299, 'h0004, 0, 0, 1, 1, -1, -1);
    add(2,  303, 'h0101, 0, 0, 1, 1, -1, -1);
    add(2,  304, 'h7FFE, 0, 0, 1, 1, -1, 3);
    add(2,  305, 'h0103, 0, 0, 1, 1, -1, -1);
    add(2, 1185, 'h0000, 1, 0, 0, 0, 1, 3);
    // T3: enable held across frames, dropped in line 5 of the third frame
    add(3, 1184, 'h0000, 1, 0, 0, 1, 0, -1);
    add(3, 1185, 'h0000, 1, 0, 0, 1, 1, -1);
    add(3, 1186, 'h7FFF, 0, 1, 0, 1, 1, -1);
    add(3, 1187, 'h4000, 0, 0, 1, 1, -1, -1);
    add(3, 1188, 'h0401, 0, 0, 1, 1, -1, -1);
    add(3, 2369, 'h0000, 1, 0, 0, 1, 2, -1);
    add(3, 2370, 'h7FFF, 0, 1, 0, 1, 2, -1);
    add(3, 3481, 'h000F, 1, 0, 1, 1, 2, -1);
    add(3, 3552, 'h0000, 1, 0, 0, 1, 2, -1);
    add(3, 3553, 'h0000, 1, 0, 0, 0, 3, 0);
    add(3, 3554, 'h0000, 0, 0, 0, 0, 3, 0);
    add(3, 3600, 'h0000, 0, 0, 0, 0, 3, 0);
    // T4: run into line 7 payload; T5: restart after async reset
    add(4,    0, 'h0000, 0, 0, 0, 0, 0, 0);
    add(4,  540, 'h01D3, 1, 0, 1, 1, 0, 0);
    add(5,    0, 'h0000, 0, 0, 0, 0, 0, 0);
    add(5,    1, 'h0000, 0, 0, 0, 1, -1, -1);
    add(5,    2, 'h7FFF, 0, 1, 0, 1, -1, -1);
    add(5,    3, 'h4000, 0, 0, 1, 1, 0, 0);

    cfgs.push_back('{1, 1190, 1,    -1,  -1,  -1});
    cfgs.push_back('{2, 1190, 1,   234, 236, 303});
    cfgs.push_back('{3, 3600, 2750, -1,  -1,  -1});

    foreach (cfgs[i]) begin
      apply_reset();
      run(cfgs[i]);
    end

    // Async reset in the middle of line 7's payload.
    apply_reset();
    c = '{4, 540, 1, -1, -1, -1};
    run(c);
    #1 rst_n = 1'b0;
    #1;
    chk("RST tx_data", 540, 32'(bus.tx_data), 32'h0);
    chk("RST tx_group", 540, 32'(bus.tx_group), 32'h0);
    chk("RST tx_sync", 540, 32'(bus.tx_sync), 32'h0);
    chk("RST s_ready", 540, 32'(bus.s_ready), 32'h0);
    chk("RST busy", 540, 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    c = '{5, 4, 1, -1, -1, -1};
    run(c);

    // Loopback of the small instance into a bench-side line receiver.
    apply_reset();
    st = 0; k = 0; nl = 0; src = 1;
    for (int t = 0; t <= 40; t++) begin
      @(negedge clk);
      if (bus2.tx_data == {DW{1'b1}}) begin
        st = 1;
      end else if (st == 1) begin
        if (nl < 2) begin
          hdr[nl] = int'(bus2.tx_data);
          grp[nl] = int'(bus2.tx_group);
        end
        st = 2;
        k = 0;
      end else if (st == 2) begin
        if (nl < 2) cap[nl*4 + k] = bus2.tx_data;
        k++;
        if (k == 4) begin
          nl++;
          st = 0;
        end
      end
      enable2 = (t == 0);
      bus2.s_valid = 1'b1;
      bus2.s_data = src[DW-1:0];
      if (bus2.s_ready) begin
        srcq.push_back(src);
        src++;
      end
    end
    enable2 = 1'b0;
    chk("LB lines", 0, 32'(nl), 32'd2);
    chk("LB words sent", 0, 32'(srcq.size()), 32'd8);
    if (nl == 2 && srcq.size() == 8) begin
      chk("LB hdr0", 0, 32'(hdr[0]), 32'h4000);
      chk("LB hdr1", 1, 32'(hdr[1]), 32'h0001);
      chk("LB grp0", 0, 32'(grp[0]), 32'd0);
      chk("LB grp1", 1, 32'(grp[1]), 32'd1);
      for (int i = 0; i < 8; i++) chk("LB payload", i, 32'(cap[i]), 32'(srcq[i]));
    end
    chk("LB frame_cnt", 40, 32'(frame_cnt2), 32'd1);
    chk("LB busy", 40, 32'(busy2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
